// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op and state encodings, flag bit positions.
// Consumers import alu_pkg::* ; the accumulator option lives in alu_seq (ALU_SEQ_ACC_EN).
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Assemble the {N,Z,C,V} status word.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  function automatic logic is_shift(input op_t o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ops (ADD/SUB/OR/AND/XOR) with N/Z/C/V flags.
// Shift ops yield zero here; they are iterated in alu_seq.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  op_t               i_op,
  input  logic [N-1:0]      i_a,
  input  logic [N-1:0]      i_b,
  output logic [N-1:0]      o_result_c,
  output logic [FLAG_W-1:0] o_flags_c
);

  logic [N:0]   w_sum;
  logic [N:0]   w_diff;
  logic [N-1:0] w_res;
  logic         w_c;
  logic         w_v;

  // Extra top bit carries the carry-out / borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
      end
      OP_SUB: begin
        w_res = w_diff[N-1:0];
        w_c   = w_diff[N];
        w_v   = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
      end
      OP_OR:   w_res = i_a | i_b;
      OP_AND:  w_res = i_a & i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      default: w_res = '0;
    endcase
  end

  assign o_result_c = w_res;
  assign o_flags_c  = pack_flags(w_res[N-1], (w_res == '0), w_c, w_v);

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready-handshaked ALU with one-bit-per-clock shifts.
// Define ALU_SEQ_ACC_EN to add the accumulator that can stand in for operand A.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_t               op,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic              use_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      Result,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned SHW = $clog2(N);

  state_t              r_state;
  state_t              w_state_next;
  op_t                 r_op;
  logic [SHW-1:0]      r_cnt;
  logic [N-1:0]        r_result;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_release;
  logic                w_shift_op;
  logic [SHW-1:0]      w_amt;
  logic [N-1:0]        w_a;
  logic [N-1:0]        w_core_result;
  logic [FLAG_W-1:0]   w_core_flags;
  logic [N-1:0]        w_step;
  logic                w_step_out;

  assign in_ready   = (r_state == IDLE) && !reset;
  assign w_accept   = in_valid && in_ready;
  assign w_release  = (r_state == HOLD) && out_ready;
  assign w_shift_op = is_shift(op);
  assign w_amt      = B[SHW-1:0];

`ifdef ALU_SEQ_ACC_EN
  logic [N-1:0] r_acc;

  // Accumulator captures every delivered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_release) begin
      r_acc <= r_result;
    end
  end

  assign w_a = use_acc ? r_acc : A;
`else
  logic w_unused_acc;
  assign w_unused_acc = use_acc;
  assign w_a          = A;
`endif

  alu_core #(
    .N (N)
  ) u_core (
    .i_op       (op),
    .i_a        (w_a),
    .i_b        (B),
    .o_result_c (w_core_result),
    .o_flags_c  (w_core_flags)
  );

  // One shift step of the working value; r_result doubles as the shift register.
  always_comb begin
    w_step     = r_result;
    w_step_out = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_step     = {r_result[N-2:0], 1'b0};
        w_step_out = r_result[N-1];
      end
      OP_SRL: begin
        w_step     = {1'b0, r_result[N-1:1]};
        w_step_out = r_result[0];
      end
      OP_SRA: begin
        w_step     = {r_result[N-1], r_result[N-1:1]};
        w_step_out = r_result[0];
      end
      default: w_step = r_result;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (w_shift_op && (w_amt != '0)) ? SHIFT : HOLD;
        end
      end
      SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_ADD;
      r_cnt       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == HOLD);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op <= op;
            if (w_shift_op) begin
              r_result <= w_a;
              r_cnt    <= w_amt;
              r_flags  <= pack_flags(w_a[N-1], (w_a == '0), 1'b0, 1'b0);
            end else begin
              r_result <= w_core_result;
              r_flags  <= w_core_flags;
            end
          end
        end
        SHIFT: begin
          r_result <= w_step;
          r_cnt    <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_flags <= pack_flags(w_step[N-1], (w_step == '0), w_step_out, 1'b0);
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=16): directed plan cases plus randomized ops
// against an arithmetic reference model. Honours ALU_SEQ_ACC_EN when defined.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned N = 16;
`ifdef ALU_SEQ_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  op_t          op = OP_ADD;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         use_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] Result;
  logic [3:0]   flags;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] acc = '0;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] f);
    int          k;
    int          sa;
    int          sb;
    int          s;
    logic [31:0] w;
    logic        c;
    logic        v;
    k  = int'(b[3:0]);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    case (o)
      3'd0: begin
        w = 32'(a) + 32'(b); r = w[15:0]; c = w[16];
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        w = 32'(a) - 32'(b); r = w[15:0]; c = (a < b);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      3'd5: begin w = 32'(a) << k; r = w[15:0]; c = w[16]; end
      3'd6: begin w = {a, 16'h0000} >> k; r = w[31:16]; c = w[15]; end
      default: begin w = 32'($signed({a, 16'h0000}) >>> k); r = w[31:16]; c = w[15]; end
    endcase
    f = {r[15], (r == 16'h0000), c, v};
  endfunction

  // Drive one transaction and report what the DUT did; comparisons happen in the callers.
  task automatic run_txn(input op_t o, input logic [15:0] a, input logic [15:0] b, input logic ua,
                         input int stall, output logic [15:0] res, output logic [3:0] fl,
                         output int lat, output logic bad, output logic post_ov, output logic post_ir);
    bad = 1'b0;
    @(negedge clk);
    op = o; A = a; B = b; use_acc = ua; in_valid = 1'b1;
    if (!in_ready) bad = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom);
    op = op_t'(3'($urandom_range(0, 7))); use_acc = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = Result;
    fl  = flags;
    repeat (stall) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (Result !== res || flags !== fl || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    post_ov = out_valid;
    post_ir = in_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; op = OP_ADD; A = 16'h1234; B = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", Result); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    acc = '0;
  endtask

  task automatic test_directed();
    op_t          ops [6]  = '{OP_ADD, OP_SUB, OP_SUB, OP_SRA, OP_SLL, OP_OR};
    logic [15:0]  as  [6]  = '{16'hFFFF, 16'h8000, 16'h0003, 16'h8010, 16'h1234, 16'h00F0};
    logic [15:0]  bs  [6]  = '{16'h0001, 16'h0001, 16'h0005, 16'h0004, 16'h0000, 16'h0F00};
    logic [15:0]  er  [6]  = '{16'h0000, 16'h7FFF, 16'hFFFE, 16'hF801, 16'h1234, 16'h0FF0};
    logic [3:0]   ef  [6]  = '{4'b0110, 4'b0001, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
    int           el  [6]  = '{1, 1, 1, 5, 1, 1};
    int           st  [6]  = '{0, 0, 1, 0, 0, 3};
    logic [15:0]  res;
    logic [3:0]   fl;
    int           lat;
    logic         bad, pov, pir;
    for (int i = 0; i < 6; i++) begin
      run_txn(ops[i], as[i], bs[i], 1'b0, st[i], res, fl, lat, bad, pov, pir);
      acc = er[i];
      checks++; if (res !== er[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, er[i]); end
      checks++; if (fl !== ef[i]) begin errors++; $display("FAIL dir%0d_flags got=%b exp=%b", i, fl, ef[i]); end
      checks++; if (lat != el[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL dir%0d_handshake got=%b exp=0", i, bad); end
      checks++; if (pov !== 1'b0 || pir !== 1'b1) begin
        errors++; $display("FAIL dir%0d_release out_valid=%b in_ready=%b exp 0/1", i, pov, pir);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] res;
    logic [3:0]  fl;
    int          lat;
    logic        bad, pov, pir, seen;
    @(negedge clk);
    op = OP_SRL; A = 16'hFFFF; B = 16'h0008; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL shift_busy in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || Result !== 16'h0000 || flags !== 4'h0) begin
      errors++; $display("FAIL mid_reset out_valid=%b result=%h flags=%h exp 0/0000/0", out_valid, Result, flags);
    end
    @(negedge clk); reset = 1'b0; #1;
    acc = '0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle in_ready got=%b exp=1", in_ready); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abandoned_result out_valid seen=%b exp=0", seen); end
    run_txn(OP_AND, 16'h00FF, 16'h0F0F, 1'b0, 0, res, fl, lat, bad, pov, pir);
    acc = 16'h000F;
    checks++; if (res !== 16'h000F || fl !== 4'b0000) begin
      errors++; $display("FAIL after_reset_and result=%h flags=%b exp 000F/0000", res, fl);
    end
  endtask

  task automatic test_accumulator();
    logic [15:0] res;
    logic [15:0] exp_r;
    logic [3:0]  fl;
    int          lat;
    logic        bad, pov, pir;
    run_txn(OP_ADD, 16'h0005, 16'h0000, 1'b0, 0, res, fl, lat, bad, pov, pir);
    acc = 16'h0005;
    checks++; if (res !== 16'h0005) begin errors++; $display("FAIL acc_seed got=%h exp=0005", res); end
    run_txn(OP_ADD, 16'h1111, 16'h0003, 1'b1, 0, res, fl, lat, bad, pov, pir);
    exp_r = ACC_ON ? 16'h0008 : 16'h1114;
    acc = exp_r;
    checks++; if (res !== exp_r) begin errors++; $display("FAIL acc_use got=%h exp=%h", res, exp_r); end
  endtask

  task automatic test_random();
    op_t         o;
    logic [15:0] a, b, a_eff, exp_r, res;
    logic [3:0]  exp_f, fl;
    logic        ua, bad, pov, pir;
    int          lat, exp_lat, stall;
    for (int i = 0; i < 60; i++) begin
      o     = op_t'(3'($urandom_range(0, 7)));
      a     = 16'($urandom);
      b     = 16'($urandom);
      if (i % 4 == 0) b = {12'($urandom), 4'h0};
      ua    = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 2);
      a_eff = (ACC_ON && ua) ? acc : a;
      model(3'(o), a_eff, b, exp_r, exp_f);
      exp_lat = (o inside {OP_SLL, OP_SRL, OP_SRA}) ? 1 + int'(b[3:0]) : 1;
      run_txn(o, a, b, ua, stall, res, fl, lat, bad, pov, pir);
      acc = exp_r;
      checks++; if (res !== exp_r) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a_eff, b, res, exp_r); end
      checks++; if (fl !== exp_f) begin errors++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h got=%b exp=%b", i, o, a_eff, b, fl, exp_f); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      checks++; if (bad !== 1'b0 || pov !== 1'b0 || pir !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_handshake bad=%b out_valid=%b in_ready=%b exp 0/0/1", i, bad, pov, pir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_accumulator();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, handshaked successor of the team's 4-op combinational ALU.
- Extends the op set to 8 ops. Adds N/Z/C/V status flags.
- Shifts are iterative, one bit per clock, to keep the datapath small on FPGA.
- Sits between the operand/switch front-end and the display/register stage, with valid/ready on both sides.

Parameters:
- N, 16, operand/result width in bits (N >= 2).
- SHW, $clog2(N), localparam: width of the shift amount taken from B[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE and not in reset.
- op  in  3  operation, type alu_pkg::op_t.
- A  in  N  operand A.
- B  in  N  operand B; shift amount = B[SHW-1:0].
- use_acc  in  1  substitute the internal accumulator for A (ALU_SEQ_ACC_EN only; ignored otherwise).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  N  registered result.
- flags  out  4  {N,Z,C,V}, registered.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, Result=0, flags=0, out_valid=0, in_ready=0 while reset is high. Accumulator=0.
- Op encoding:
  - 000 ADD, 001 SUB, 010 OR, 011 AND.
  - 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch op, A, B.
  - Non-shift op: compute, register Result/flags, go to HOLD. out_valid is high on the cycle after accept (latency 1).
  - Shift op with amount 0: Result=A, C=0, go to HOLD (latency 1).
  - Shift op with amount k>0: load the working register with A and a counter with k, go to SHIFT.
- SHIFT:
  - Shift one bit per cycle; decrement the counter.
  - When the counter reaches 0, go to HOLD.
  - Latency from accept to out_valid = 1+k cycles.
- HOLD:
  - out_valid=1.
  - Result and flags stay stable until out_ready.
  - On out_valid&&out_ready: go to IDLE, deassert out_valid the next cycle.
  - No overlap: in_ready=0 in SHIFT and HOLD. in_valid in those states is ignored, not queued.
- Input stability: operands are latched at accept; later changes on A/B/op have no effect on the op in flight.
- Arithmetic: all ops are modulo 2^N.
  - SRA replicates the sign bit.
  - SRL and SLL fill with 0.
- Flags:
  - Z: Result==0.
  - N: Result[N-1].
  - C for ADD: carry out of bit N-1.
  - C for SUB: borrow, i.e. A<B unsigned.
  - C for shifts: last bit shifted out.
  - C for logic ops: 0.
  - V for ADD/SUB: two's-complement overflow. V for all other ops: 0.
- Reset mid-operation (SHIFT or HOLD): abandon the op; next cycle is IDLE with out_valid=0 and Result=0. No partial result is delivered.
- Simultaneous reset and in_valid: reset wins; nothing is accepted.

Optional Feature:
- Macro: ALU_SEQ_ACC_EN.
- Defined:
  - An N-bit accumulator loads Result on each out handshake.
  - If use_acc=1 at accept, the accumulator value replaces A.
  - Reset clears the accumulator.
- Undefined:
  - No accumulator register.
  - use_acc is present but ignored; A is always the port value.

Decomposition:
- alu_pkg holds:
  - op_t enum (3-bit, encoding above).
  - state_t enum {IDLE, SHIFT, HOLD}.
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module: alu_core, the combinational single-cycle ops (ADD/SUB/OR/AND/XOR plus flags).
- alu_seq holds the FSM, shift iterator, handshake and accumulator.

Test Plan (N=16):
- ADD A=0xFFFF B=0x0001 -> one cycle after accept: out_valid=1, Result=0x0000, flags N=0 Z=1 C=1 V=0.
- SUB A=0x8000 B=0x0001 -> Result=0x7FFF, N=0 Z=0 C=0 V=1. Then SUB A=0x0003 B=0x0005 -> Result=0xFFFE, N=1 C=1 V=0.
- SRA A=0x8010 B=0x0004 -> out_valid exactly 5 cycles after accept, Result=0xF801, C=0, in_ready=0 throughout. SLL A=0x1234 B=0x0000 -> latency 1, Result=0x1234, C=0.
- Backpressure: complete OR A=0x00F0 B=0x0F00 with out_ready=0 for 3 cycles, pulsing in_valid meanwhile -> Result=0x0FF0 held stable, in_ready=0, no extra accept; IDLE the cycle after out_ready=1.
- Reset asserted 2 cycles into SRL A=0xFFFF B=0x0008 -> next cycle IDLE, out_valid=0, Result=0x0000, flags=0; a following AND A=0x00FF B=0x0F0F -> Result=0x000F.
- With ALU_SEQ_ACC_EN: ADD A=5 B=0 delivered, then ADD use_acc=1 A=0x1111 B=3 -> Result=0x0008. Without the macro, the same stimulus gives 0x1114.
